// File: rtl/fc_pkg.sv
// Shared fixed-point formats and default sizes for the FC layer, its neurons
// and the vector serializer that follows it.
package fc_pkg;

    localparam int FC_DIM    = 8;
    localparam int ACT_W     = 8;
    localparam int ACT_FRAC  = 7;
    localparam int FEAT_W    = 16;
    localparam int FEAT_FRAC = 7;

    typedef logic signed [ACT_W-1:0]  act8_t;    // [1,7]
    typedef logic signed [FEAT_W-1:0] feat16_t;  // [9,7]

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } ser_state_t;

endpackage

// File: rtl/fc_vec_serializer_if.sv
// Parallel-in / serial-out bundle between the FC layer and the next layer.
interface fc_vec_serializer_if
    import fc_pkg::*;
#(
    parameter int DIM   = FC_DIM,
    parameter int IN_W  = ACT_W,
    parameter int OUT_W = FEAT_W
);

    logic [IN_W-1:0]  in_dat [DIM-1:0];
    logic             in_valid;
    logic [OUT_W-1:0] out_dat;
    logic             out_valid;
    logic             out_last;
    logic             busy;
    logic             ovf_err;

    // master: the producing layer / consumer side; slave: the serializer
    modport master (
        output in_dat, in_valid,
        input  out_dat, out_valid, out_last, busy, ovf_err
    );

    modport slave (
        input  in_dat, in_valid,
        output out_dat, out_valid, out_last, busy, ovf_err
    );

endinterface

// File: rtl/fx_realign.sv
// Lossless fixed-point realignment: sign-extend to OUT_W, then shift left so
// the binary point moves from IN_FRAC to OUT_FRAC.
module fx_realign #(
    parameter int IN_W     = 8,
    parameter int IN_FRAC  = 7,
    parameter int OUT_W    = 16,
    parameter int OUT_FRAC = 7
) (
    input  logic [IN_W-1:0]  in_elem,
    output logic [OUT_W-1:0] out_elem
);

    localparam int SHIFT = OUT_FRAC - IN_FRAC;

    logic signed [OUT_W-1:0] ext;

    always_comb begin
        ext      = OUT_W'($signed(in_elem));
        out_elem = ext << SHIFT;
    end

endmodule

// File: rtl/fc_vec_serializer.sv
// Streams a DIM-wide layer output vector one realigned element per cycle,
// with one pending vector slot so back-to-back vectors leave no bubble.
module fc_vec_serializer
    import fc_pkg::*;
#(
    parameter int DIM      = FC_DIM,
    parameter int IN_W     = ACT_W,
    parameter int IN_FRAC  = ACT_FRAC,
    parameter int OUT_W    = FEAT_W,
    parameter int OUT_FRAC = FEAT_FRAC
) (
    input  logic                clk,
    input  logic                rst_n,
    fc_vec_serializer_if.slave  bus
);

    localparam int              IDX_W = (DIM > 1) ? $clog2(DIM) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(DIM - 1);

    ser_state_t       state, next_state;
    logic [IN_W-1:0]  act_buf  [DIM-1:0];
    logic [IN_W-1:0]  pend_buf [DIM-1:0];
    logic             pend_vld, pend_vld_d;
    logic [IDX_W-1:0] idx, idx_d;

    logic             at_last;
    logic             act_from_in, act_from_pend, pend_from_in;
    logic [IN_W-1:0]  sel_elem;
    logic [OUT_W-1:0] sel_conv;
    logic             valid_d, last_d, busy_d, ovf_d;

    logic [OUT_W-1:0] out_dat_q;
    logic             out_valid_q, out_last_q, busy_q, ovf_q;

    assign at_last = (state == STREAM) && (idx == LAST);

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.in_valid) next_state = STREAM;
            STREAM:  if (at_last && !pend_vld && !bus.in_valid) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // idx tracks the element shown on out_dat; everything here is the value
    // the output registers take at the next edge.
    // NOTE: every signal gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        idx_d         = idx;
        pend_vld_d    = pend_vld;
        act_from_in   = 1'b0;
        act_from_pend = 1'b0;
        pend_from_in  = 1'b0;
        sel_elem      = '0;
        valid_d       = 1'b0;
        ovf_d         = 1'b0;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    act_from_in = 1'b1;
                    idx_d       = '0;
                    sel_elem    = bus.in_dat[0];
                    valid_d     = 1'b1;
                end
            end
            STREAM: begin
                if (at_last) begin
                    idx_d = '0;
                    if (pend_vld) begin
                        act_from_pend = 1'b1;
                        sel_elem      = pend_buf[0];
                        valid_d       = 1'b1;
                        pend_from_in  = bus.in_valid;
                        pend_vld_d    = bus.in_valid;
                    end else if (bus.in_valid) begin
                        act_from_in = 1'b1;
                        sel_elem    = bus.in_dat[0];
                        valid_d     = 1'b1;
                    end
                end else begin
                    idx_d    = idx + 1'b1;
                    sel_elem = act_buf[idx_d];
                    valid_d  = 1'b1;
                    if (bus.in_valid) begin
                        if (pend_vld) begin
                            ovf_d = 1'b1;
                        end else begin
                            pend_from_in = 1'b1;
                            pend_vld_d   = 1'b1;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    assign last_d = valid_d && (idx_d == LAST);
    assign busy_d = (next_state == STREAM) || pend_vld_d;

    fx_realign #(
        .IN_W     (IN_W),
        .IN_FRAC  (IN_FRAC),
        .OUT_W    (OUT_W),
        .OUT_FRAC (OUT_FRAC)
    ) u_realign (
        .in_elem  (sel_elem),
        .out_elem (sel_conv)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx         <= '0;
            pend_vld    <= 1'b0;
            out_dat_q   <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            idx         <= idx_d;
            pend_vld    <= pend_vld_d;
            out_dat_q   <= valid_d ? sel_conv : '0;
            out_valid_q <= valid_d;
            out_last_q  <= last_d;
            busy_q      <= busy_d;
            ovf_q       <= ovf_d;
        end
    end

    // NOTE: vector buffers carry no reset; pend_vld and state qualify them, so
    // stale contents are never observed and the arrays stay plain storage.
    always_ff @(posedge clk) begin
        if (act_from_in)        act_buf <= bus.in_dat;
        else if (act_from_pend) act_buf <= pend_buf;
        if (pend_from_in)       pend_buf <= bus.in_dat;
    end

    assign bus.out_dat   = out_dat_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.busy      = busy_q;
    assign bus.ovf_err   = ovf_q;

endmodule
